// File: rtl/alu_v3.sv
// Three-stage signed fixed-point ALU with multiply-accumulate, saturation/wrap
// and valid/ready flow control on both sides.
module alu_v3 #(
  parameter int BUS_WIDTH = 8,
  parameter int FRAC_BITS = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [BUS_WIDTH-1:0] sw,
  input  logic [BUS_WIDTH-1:0] imm,
  input  logic [BUS_WIDTH-1:0] data_a,
  input  logic [BUS_WIDTH-1:0] data_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 ovf
);

  localparam int W  = BUS_WIDTH;
  localparam int PW = 2 * BUS_WIDTH;
  localparam int WW = 2 * BUS_WIDTH + 1;

  localparam logic signed [WW-1:0] MAX_V = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_V = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
  localparam logic [W-1:0] MAX_R = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] MIN_R = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [2:0] {
    OP_LOAD   = 3'd0,
    OP_ADDI   = 3'd1,
    OP_ADD    = 3'd2,
    OP_SUB    = 3'd3,
    OP_MUL    = 3'd4,
    OP_MAC    = 3'd5,
    OP_CLRACC = 3'd6,
    OP_RDACC  = 3'd7
  } op_e;

  function automatic logic signed [WW-1:0] ext_w(input logic [W-1:0] x);
    return {{(WW - W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [WW-1:0] ext_p(input logic [PW-1:0] x);
    return {x[PW-1], x};
  endfunction

  // Returns {ovf, narrowed value}: clamp or wrap depending on SATURATE.
  function automatic logic [W:0] fit_f(input logic signed [WW-1:0] v);
    logic [W:0] r;
    if (v > MAX_V) begin
      r = (SATURATE != 0) ? {1'b1, MAX_R} : {1'b1, v[W-1:0]};
    end else if (v < MIN_V) begin
      r = (SATURATE != 0) ? {1'b1, MIN_R} : {1'b1, v[W-1:0]};
    end else begin
      r = {1'b0, v[W-1:0]};
    end
    return r;
  endfunction

  logic                 stall_s;
  logic [W-1:0]         k_in_s;
  logic signed [PW-1:0] prod_full_s;
  logic signed [PW-1:0] prod_sh_s;
  logic signed [WW-1:0] wide_s;
  logic                 acc_wr_s;
  logic [W:0]           fit_s;

  logic                 v1_r, v2_r, out_valid_r, ovf_r;
  op_e                  op1_r, op2_r;
  logic [W-1:0]         a1_r, b1_r, k1_r, a2_r, b2_r, k2_r;
  logic [PW-1:0]        prod2_r;
  logic [W-1:0]         result_r, acc_r;

  assign stall_s   = out_valid_r && !out_ready;
  assign in_ready  = !stall_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign ovf       = ovf_r;

  // Only LOAD and ADDI need a third operand; carry whichever one applies.
  always_comb begin
    if (op_e'(op) == OP_LOAD) begin
      k_in_s = sw;
    end else begin
      k_in_s = imm;
    end
  end

  // Stage 1: capture opcode and operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r  <= 1'b0;
      op1_r <= OP_LOAD;
      a1_r  <= '0;
      b1_r  <= '0;
      k1_r  <= '0;
    end else if (!stall_s) begin
      v1_r  <= in_valid;
      op1_r <= op_e'(op);
      a1_r  <= data_a;
      b1_r  <= data_b;
      k1_r  <= k_in_s;
    end
  end

  assign prod_full_s = $signed({{W{a1_r[W-1]}}, a1_r}) * $signed({{W{b1_r[W-1]}}, b1_r});
  assign prod_sh_s   = prod_full_s >>> FRAC_BITS;

  // Stage 2: register the scaled product alongside the forwarded operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      op2_r   <= OP_LOAD;
      a2_r    <= '0;
      b2_r    <= '0;
      k2_r    <= '0;
      prod2_r <= '0;
    end else if (!stall_s) begin
      v2_r    <= v1_r;
      op2_r   <= op1_r;
      a2_r    <= a1_r;
      b2_r    <= b1_r;
      k2_r    <= k1_r;
      prod2_r <= prod_sh_s;
    end
  end

  // Stage 3 datapath: wide enough that no function can overflow before narrowing.
  always_comb begin
    wide_s   = '0;
    acc_wr_s = 1'b0;
    case (op2_r)
      OP_LOAD:   wide_s = ext_w(k2_r);
      OP_ADDI:   wide_s = ext_w(a2_r) + ext_w(k2_r);
      OP_ADD:    wide_s = ext_w(a2_r) + ext_w(b2_r);
      OP_SUB:    wide_s = ext_w(a2_r) - ext_w(b2_r);
      OP_MUL:    wide_s = ext_p(prod2_r);
      OP_MAC: begin
        wide_s   = ext_w(acc_r) + ext_p(prod2_r);
        acc_wr_s = 1'b1;
      end
      OP_CLRACC: begin
        wide_s   = '0;
        acc_wr_s = 1'b1;
      end
      OP_RDACC:  wide_s = ext_w(acc_r);
      default:   wide_s = '0;
    endcase
  end

  assign fit_s = fit_f(wide_s);

  // Stage 3 registers: result, overflow flag and the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      ovf_r       <= 1'b0;
      acc_r       <= '0;
    end else if (!stall_s) begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        result_r <= fit_s[W-1:0];
        ovf_r    <= fit_s[W];
        if (acc_wr_s) begin
          acc_r <= fit_s[W-1:0];
        end
      end
    end
  end

endmodule
